// File: rtl/cdc_req_sender_if.sv
// cdc_req_sender_if: word/handshake bundle between the source user, the sender and the far-domain receiver
interface cdc_req_sender_if #(parameter int data_width = 8);
  logic [data_width-1:0] data_in;
  logic                  valid;
  logic                  ready;
  logic [data_width-1:0] data_out;
  logic                  req_tgl;
  logic                  ack_tgl;
  logic                  done;
  logic                  err_clr;
  logic                  timeout_err;
  modport master (
    input  data_in, valid, ack_tgl, err_clr,
    output ready, data_out, req_tgl, done, timeout_err
  );
  modport slave (
    output data_in, valid, ack_tgl, err_clr,
    input  ready, data_out, req_tgl, done, timeout_err
  );
endinterface

// File: rtl/cdc_req_sender.sv
// cdc_req_sender: source end of a two-phase toggle req/ack CDC handshake, all logic in clk_a
module cdc_req_sender #(
  parameter int data_width = 8,
  parameter int sync_size  = 2,
  parameter int timeout    = 0
) (
  input  logic               clk_a,
  input  logic               rst_n,
  cdc_req_sender_if.master   bus
);
  localparam int cw = timeout > 0 ? $clog2(timeout + 1) : 1;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t                r_state, w_state;
  logic [sync_size-1:0]  r_sync;
  logic [data_width-1:0] r_data, w_data;
  logic                  r_req, w_req;
  logic                  r_done, w_done;
  logic                  r_err, w_err;
  logic [cw-1:0]         r_cnt, w_cnt;
  logic                  w_ack_s, w_hit;
  assign w_ack_s = r_sync[sync_size-1];
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_state <= IDLE;
      r_data  <= '0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[sync_size-2:0], bus.ack_tgl};
      r_state <= w_state;
      r_data  <= w_data;
      r_req   <= w_req;
      r_done  <= w_done;
      r_err   <= w_err;
      r_cnt   <= w_cnt;
    end
  end
  // a match on the timeout edge completes the transfer instead of flagging an error
  always_comb begin
    w_state = r_state;
    w_data  = r_data;
    w_req   = r_req;
    w_done  = 1'b0;
    w_cnt   = r_cnt;
    w_hit   = 1'b0;
    if (r_state == IDLE) begin
      if (bus.valid) begin
        w_state = WAIT;
        w_data  = bus.data_in;
        w_req   = ~r_req;
        w_cnt   = '0;
      end
    end else if (w_ack_s == r_req) begin
      w_state = IDLE;
      w_done  = 1'b1;
    end else begin
      w_hit = timeout > 0 && r_cnt == cw'(timeout - 1);
      w_cnt = (timeout > 0 && r_cnt != cw'(timeout)) ? r_cnt + 1'b1 : r_cnt;
    end
    w_err = w_hit | (r_err & ~bus.err_clr);
  end
  assign bus.ready       = r_state == IDLE;
  assign bus.data_out    = r_data;
  assign bus.req_tgl     = r_req;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_err;
endmodule

// File: tb/tb_cdc_req_sender.sv
// tb_cdc_req_sender: directed bench with a transaction-level model checked on every falling edge
module tb_cdc_req_sender;
  localparam int SS = 2, TO = 8;
  logic clk_a = 1'b0, rst_n = 1'b0;
  bit echo = 1'b0;
  int checks = 0, errors = 0, done_cnt = 0;
  logic [7:0] rx[$];
  logic prev_req = 1'b0;
  bit m_busy = 1'b0, m_req = 1'b0, m_done = 1'b0, m_err = 1'b0, m_set = 1'b0;
  logic [7:0] m_data = 8'h00;
  int m_wait = 0;
  bit m_q[$];
  bit b2b_req[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] b2b_word[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  int n, d0, r0;

  cdc_req_sender_if #(.data_width(8)) bus();
  cdc_req_sender #(.data_width(8), .sync_size(SS), .timeout(TO)) dut (
    .clk_a(clk_a), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk_a = ~clk_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_a);
    #1;
    if (echo) bus.ack_tgl = bus.req_tgl;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 40) begin
      tick;
      cnt++;
    end
    chk("done_wait", 32'(bus.done), 32'h1);
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (bus.ready !== 1'b1 && cnt < 40) begin
      tick;
      cnt++;
    end
    chk("ready_wait", 32'(bus.ready), 32'h1);
  endtask

  // transaction model: ack seen after sync_size edges, WAIT length counted until timeout
  always @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_req = 1'b0; m_done = 1'b0; m_err = 1'b0; m_data = 8'h00; m_wait = 0;
      m_q = {};
      repeat (SS) m_q.push_back(1'b0);
    end else begin
      m_done = 1'b0;
      m_set  = 1'b0;
      if (!m_busy) begin
        if (bus.valid) begin
          m_busy = 1'b1; m_data = bus.data_in; m_req = !m_req; m_wait = 0;
        end
      end else if (m_q[0] == m_req) begin
        m_busy = 1'b0; m_done = 1'b1;
      end else begin
        m_wait++;
        m_set = TO > 0 && m_wait == TO;
      end
      m_err = m_set || (m_err && !bus.err_clr);
      void'(m_q.pop_front());
      m_q.push_back(bus.ack_tgl);
    end
  end

  always @(negedge clk_a) begin
    chk("ready", 32'(bus.ready), 32'(!m_busy));
    chk("data_out", 32'(bus.data_out), 32'(m_data));
    chk("req_tgl", 32'(bus.req_tgl), 32'(m_req));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
    if (!rst_n) prev_req = 1'b0;
    else begin
      if (bus.req_tgl !== prev_req) rx.push_back(bus.data_out);
      prev_req = bus.req_tgl;
    end
    if (bus.done === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.valid = 1'b0; bus.data_in = 8'h00; bus.ack_tgl = 1'b0; bus.err_clr = 1'b0;
    repeat (3) tick;
    chk("rst_ready", 32'(bus.ready), 32'h1);
    chk("rst_req", 32'(bus.req_tgl), 32'h0);
    chk("rst_data", 32'(bus.data_out), 32'h0);
    rst_n = 1'b1;
    repeat (10) begin
      tick;
      chk("idle_ready", 32'(bus.ready), 32'h1);
      chk("idle_done", 32'(bus.done), 32'h0);
    end
    // single transfer; ack arrives so that the match lands exactly on the timeout edge
    bus.valid = 1'b1; bus.data_in = 8'hA5;
    tick;
    bus.valid = 1'b0;
    chk("single_data", 32'(bus.data_out), 32'hA5);
    chk("single_req", 32'(bus.req_tgl), 32'h1);
    chk("single_busy", 32'(bus.ready), 32'h0);
    repeat (5) tick;
    bus.ack_tgl = 1'b1;
    wait_done(n);
    chk("single_latency", 32'(n), 32'd3);
    chk("single_ready", 32'(bus.ready), 32'h1);
    chk("single_noerr", 32'(bus.timeout_err), 32'h0);
    tick;
    chk("single_done_once", 32'(bus.done), 32'h0);
    // hold under pressure
    bus.valid = 1'b1; bus.data_in = 8'h3C;
    tick;
    for (int i = 0; i < 4; i++) begin
      bus.data_in = 8'h40 + 8'(i);
      tick;
      chk("hold_data", 32'(bus.data_out), 32'h3C);
      chk("hold_req", 32'(bus.req_tgl), 32'h0);
    end
    bus.ack_tgl = 1'b0;
    wait_done(n);
    bus.data_in = 8'h77;
    tick;
    bus.valid = 1'b0;
    chk("hold_next_data", 32'(bus.data_out), 32'h77);
    chk("hold_next_req", 32'(bus.req_tgl), 32'h1);
    bus.ack_tgl = 1'b1;
    wait_done(n);
    tick;
    // back-to-back with an immediately echoing receiver
    echo = 1'b1;
    d0 = done_cnt;
    r0 = rx.size();
    bus.valid = 1'b1;
    for (int w = 0; w < 4; w++) begin
      bus.data_in = b2b_word[w];
      wait_ready(n);
      tick;
      chk("b2b_req", 32'(bus.req_tgl), 32'(b2b_req[w]));
    end
    bus.valid = 1'b0;
    wait_ready(n);
    tick;
    echo = 1'b0;
    chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd4);
    chk("b2b_rx_cnt", 32'(rx.size() - r0), 32'd4);
    for (int w = 0; w < 4; w++)
      if (r0 + w < rx.size()) chk("b2b_rx_word", 32'(rx[r0 + w]), 32'(b2b_word[w]));
    // timeout
    bus.valid = 1'b1; bus.data_in = 8'hE1;
    tick;
    bus.valid = 1'b0;
    repeat (7) tick;
    chk("to_before", 32'(bus.timeout_err), 32'h0);
    tick;
    chk("to_set", 32'(bus.timeout_err), 32'h1);
    chk("to_busy", 32'(bus.ready), 32'h0);
    repeat (3) tick;
    chk("to_still_busy", 32'(bus.ready), 32'h0);
    bus.ack_tgl = bus.req_tgl;
    wait_done(n);
    chk("to_sticky", 32'(bus.timeout_err), 32'h1);
    bus.err_clr = 1'b1;
    tick;
    bus.err_clr = 1'b0;
    chk("to_clear", 32'(bus.timeout_err), 32'h0);
    bus.err_clr = 1'b1;
    tick;
    bus.err_clr = 1'b0;
    chk("clr_idle_ready", 32'(bus.ready), 32'h1);
    chk("clr_idle_req", 32'(bus.req_tgl), 32'h0);
    // reset in the middle of WAIT
    bus.valid = 1'b1; bus.data_in = 8'h5A;
    tick;
    bus.valid = 1'b0;
    repeat (2) tick;
    chk("mid_busy", 32'(bus.ready), 32'h0);
    #2;
    rst_n = 1'b0;
    bus.ack_tgl = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.ready), 32'h1);
    chk("mid_rst_req", 32'(bus.req_tgl), 32'h0);
    chk("mid_rst_data", 32'(bus.data_out), 32'h0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    bus.valid = 1'b1; bus.data_in = 8'h99;
    tick;
    bus.valid = 1'b0;
    chk("post_rst_req", 32'(bus.req_tgl), 32'h1);
    chk("post_rst_data", 32'(bus.data_out), 32'h99);
    repeat (2) tick;
    bus.ack_tgl = 1'b1;
    wait_done(n);
    chk("post_rst_lat", 32'(n), 32'd3);
    repeat (3) tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
